// File: rtl/player_jump_ctrl_pkg.sv
// player_pkg: shared types and default tuning constants for the player
// vertical-motion controller.
//   jump_state_t : vertical-motion FSM states
//   vel_t        : signed 10-bit per-frame velocity (pixels/frame)
//   cnt_w()      : counter width helper with a floor
package player_pkg;

  typedef enum logic [2:0] {
    GROUND,
    RISE,
    FALL,
    LAND,
    RESPAWN
  } jump_state_t;

  localparam int VEL_W          = 10;
  localparam int JUMP_V0        = 8;
  localparam int GRAVITY_DIV    = 3;
  localparam int MAX_FALL       = 6;
  localparam int RESPAWN_FRAMES = 60;

  typedef logic signed [VEL_W-1:0] vel_t;

  // Counter width able to hold 0..n-1, never narrower than min_w.
  function automatic int cnt_w(input int n, input int min_w);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return (w < min_w) ? min_w : w;
  endfunction

endpackage

// File: rtl/player_jump_ctrl_if.sv
// player_jump_ctrl_if: frame-paced control/status bundle between the input
// decoder / movement datapath (master) and the jump controller (slave).
//   frame_tick, game_active, jump_req, on_platform, respawn_req : to ctrl
//   y_velocity, airborne, jump_ack, respawn_pulse               : from ctrl
interface player_jump_ctrl_if;
  import player_pkg::*;

  logic frame_tick;
  logic game_active;
  logic jump_req;
  logic on_platform;
  logic respawn_req;
  vel_t y_velocity;
  logic airborne;
  logic jump_ack;
  logic respawn_pulse;

  modport master (
    output frame_tick, game_active, jump_req, on_platform, respawn_req,
    input  y_velocity, airborne, jump_ack, respawn_pulse
  );

  modport slave (
    input  frame_tick, game_active, jump_req, on_platform, respawn_req,
    output y_velocity, airborne, jump_ack, respawn_pulse
  );
endinterface

// File: rtl/player_jump_ctrl_edge.sv
// edge_detect_rise: rising-edge detector. The previous level is registered;
// the pulse itself is combinational on din so an edge arriving in the same
// Clk as a frame tick is seen by that tick.
//   Clk, Reset_n : clock, async active-low reset
//   din          : level input
//   rise         : high for the one Clk where din goes 0 -> 1
module edge_detect_rise (
  input  logic Clk,
  input  logic Reset_n,
  input  logic din,
  output logic rise
);
  logic prev_q, prev_d;

  always_comb prev_d = din;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) prev_q <= 1'b0;
    else          prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;
endmodule

// File: rtl/player_jump_ctrl.sv
// player_jump_ctrl: frame-paced jump/fall/land/respawn sequencer. Produces
// the registered signed vertical velocity added to PlayerY each frame.
//   Clk, Reset_n : clock, async active-low reset
//   bus (slave)  : frame_tick/game_active/jump_req/on_platform/respawn_req in,
//                  y_velocity/airborne/jump_ack/respawn_pulse out (registered)
module player_jump_ctrl
  import player_pkg::*;
#(
  parameter int JUMP_V0        = player_pkg::JUMP_V0,
  parameter int GRAVITY_DIV    = player_pkg::GRAVITY_DIV,
  parameter int MAX_FALL       = player_pkg::MAX_FALL,
  parameter int RESPAWN_FRAMES = player_pkg::RESPAWN_FRAMES
) (
  input logic Clk,
  input logic Reset_n,
  player_jump_ctrl_if.slave bus
);
  localparam int GW = cnt_w(GRAVITY_DIV, 1);
  localparam int RW = cnt_w(RESPAWN_FRAMES, 6);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_DIV - 1);
  localparam logic [RW-1:0] RESP_LAST = RW'(RESPAWN_FRAMES - 1);
  localparam vel_t LAUNCH_V = vel_t'(-JUMP_V0);
  localparam vel_t MAX_V    = vel_t'(MAX_FALL);

  jump_state_t   state_q, state_d;
  vel_t          vy_q, vy_d;
  logic [GW-1:0] grav_q, grav_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pend_q, pend_d;
  logic          air_q, air_d;
  logic          ack_q, ack_d;
  logic          rsp_q, rsp_d;

  logic          jump_rise, pend_now, grav_wrap;
  logic [GW-1:0] grav_inc;
  logic [RW-1:0] rcnt_inc;
  vel_t          vy_inc;

  edge_detect_rise u_jump_edge (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .din    (bus.jump_req),
    .rise   (jump_rise)
  );

  always_comb begin
    // an edge in the tick cycle itself still counts for that tick
    pend_now  = pend_q | jump_rise;
    grav_wrap = (grav_q == GRAV_LAST);
    grav_inc  = grav_wrap ? '0 : grav_q + 1'b1;
    vy_inc    = grav_wrap ? vy_q + vel_t'(1) : vy_q;
    rcnt_inc  = rcnt_q + 1'b1;

    state_d = state_q;
    vy_d    = vy_q;
    grav_d  = grav_q;
    rcnt_d  = rcnt_q;
    pend_d  = pend_now;
    ack_d   = 1'b0;
    rsp_d   = 1'b0;

    if (bus.frame_tick) begin
      pend_d = 1'b0;  // pending jump lives for one frame only
      if (!bus.game_active) begin
        state_d = GROUND;
        vy_d    = '0;
        grav_d  = '0;
      end else if (bus.respawn_req) begin
        // counter is held at 0 until the request drops
        state_d = RESPAWN;
        vy_d    = '0;
        rcnt_d  = '0;
        rsp_d   = (state_q != RESPAWN);
      end else begin
        case (state_q)
          GROUND, LAND: begin
            if (state_q == GROUND && !bus.on_platform) begin
              state_d = FALL;
              vy_d    = '0;
              grav_d  = '0;
            end else if (pend_now) begin
              state_d = RISE;
              vy_d    = LAUNCH_V;
              grav_d  = '0;
              ack_d   = 1'b1;
            end else begin
              state_d = GROUND;
              vy_d    = '0;
            end
          end
          RISE: begin
            vy_d   = vy_inc;
            grav_d = grav_inc;
            if (vy_inc == '0) state_d = FALL;
          end
          FALL: begin
            if (bus.on_platform) begin
              state_d = LAND;
              vy_d    = '0;
            end else begin
              grav_d = grav_inc;
              vy_d   = (vy_inc > MAX_V) ? MAX_V : vy_inc;
            end
          end
          RESPAWN: begin
            rcnt_d = rcnt_inc;
            if (rcnt_inc >= RESP_LAST) begin
              state_d = FALL;
              vy_d    = '0;
              grav_d  = '0;
            end
          end
          default: begin
            state_d = GROUND;
            vy_d    = '0;
          end
        endcase
      end
    end

    air_d = (state_d == RISE) || (state_d == FALL);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= GROUND;
      vy_q    <= '0;
      grav_q  <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      air_q   <= 1'b0;
      ack_q   <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vy_q    <= vy_d;
      grav_q  <= grav_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      air_q   <= air_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.y_velocity    = vy_q;
  assign bus.airborne      = air_q;
  assign bus.jump_ack      = ack_q;
  assign bus.respawn_pulse = rsp_q;
endmodule
